// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq -- sequential AES key schedule (FIPS-197) with a
// round-key read port.
//
// A start in IDLE latches the key length, loads the first Nk words from
// key_in in one cycle, then produces one schedule word per cycle until all
// 4*(Nr+1) words are in the store. A one-cycle FIN state pulses done and
// raises key_valid.
//
// Optional feature: define AES_KEY_INV_MIX_EN to apply InvMixColumns to the
// inner decryption-order round keys (equivalent inverse cipher).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      expansion request, sampled only in IDLE
//   key_len    00=128, 01=192, 10=256, 11=reserved
//   key_in     cipher key, big-endian, shorter keys left-aligned
//   rd_addr    round-key index 0..Nr
//   rd_dec     0: round rd_addr, 1: round Nr-rd_addr
//   busy       high while loading/expanding
//   done       one-cycle pulse when the schedule is complete
//   key_valid  store holds a complete schedule
//   err        one-cycle pulse after a start with an unsupported key_len
//   rd_data    selected round key (zero when invalid or out of range)
module aes_key_expand_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic [3:0]   rd_addr,
  input  logic         rd_dec,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err,
  output logic [127:0] rd_data
);

  localparam int NR_MAX = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int WORDS  = 4 * (NR_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] store [WORDS];
  logic [3:0]  nk_reg, nr_reg;
  logic [5:0]  idx_reg;     // index of the word being produced
  logic [2:0]  mod_reg;     // idx_reg mod Nk, kept as a wrap counter
  logic [7:0]  rcon_reg;
  logic        key_valid_reg, err_reg;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, zero maps to zero)
  // followed by the affine transform, so no table is needed.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // --------------------------------------------------------- key length
  logic       legal;
  logic [3:0] nk_sel, nr_sel;

  always_comb begin
    legal  = 1'b0;
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    case (key_len)
      2'b00: legal = (MAX_KEY_BITS >= 128);
      2'b01: begin legal = (MAX_KEY_BITS >= 192); nk_sel = 4'd6; nr_sel = 4'd12; end
      2'b10: begin legal = (MAX_KEY_BITS >= 256); nk_sel = 4'd8; nr_sel = 4'd14; end
      default: legal = 1'b0;
    endcase
  end

  // ------------------------------------------------------ word generator
  logic [31:0] w_prev, w_back, sub_in, sub_out, new_word;
  logic        last_word;

  assign w_prev    = store[idx_reg - 6'd1];
  assign w_back    = store[idx_reg - {2'b00, nk_reg}];
  assign sub_in    = (mod_reg == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_out   = sub_word(sub_in);
  assign last_word = (idx_reg == {nr_reg, 2'b11});   // 4*Nr+3

  always_comb begin
    new_word = w_back ^ w_prev;
    if (mod_reg == 3'd0)
      new_word = w_back ^ sub_out ^ {rcon_reg, 24'h000000};
    else if (nk_reg == 4'd8 && mod_reg == 3'd4)
      new_word = w_back ^ sub_out;
  end

  // ----------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && legal) state_next = LOAD;
      LOAD:    state_next = EXPAND;
      EXPAND:  if (last_word) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      nk_reg        <= 4'd4;
      nr_reg        <= 4'd10;
      idx_reg       <= 6'd0;
      mod_reg       <= 3'd0;
      rcon_reg      <= 8'h01;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= (state_reg == IDLE) && start && !legal;
      case (state_reg)
        IDLE: begin
          if (start && legal) begin
            nk_reg        <= nk_sel;
            nr_reg        <= nr_sel;
            key_valid_reg <= 1'b0;
          end
        end
        LOAD: begin
          idx_reg  <= {2'b00, nk_reg};
          mod_reg  <= 3'd0;
          rcon_reg <= 8'h01;
        end
        EXPAND: begin
          idx_reg <= idx_reg + 6'd1;
          mod_reg <= ({1'b0, mod_reg} == nk_reg - 4'd1) ? 3'd0 : mod_reg + 3'd1;
          if (mod_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
          if (last_word) key_valid_reg <= 1'b1;
        end
        default: begin
          idx_reg <= 6'd0;
          mod_reg <= 3'd0;
        end
      endcase
    end
  end

  // Word store: no reset, its contents are ignored while key_valid is low.
  always_ff @(posedge clk) begin
    if (state_reg == LOAD) begin
      for (int k = 0; k < 8; k++)
        if (k < int'(nk_reg)) store[6'(k)] <= key_in[255 - 32*k -: 32];
    end else if (state_reg == EXPAND) begin
      store[idx_reg] <= new_word;
    end
  end

  // ----------------------------------------------------------- read port
  logic [3:0]   rd_round;
  logic         rd_ok;
  logic [5:0]   rd_base;
  logic [127:0] raw_key;

  assign rd_round = rd_dec ? (nr_reg - rd_addr) : rd_addr;
  assign rd_ok    = key_valid_reg && (rd_addr <= nr_reg);
  assign rd_base  = rd_ok ? {rd_round, 2'b00} : 6'd0;   // keep the index in range
  assign raw_key  = {store[rd_base], store[rd_base + 6'd1],
                     store[rd_base + 6'd2], store[rd_base + 6'd3]};

`ifdef AES_KEY_INV_MIX_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic apply_imc;
  // Only the inner decryption rounds get InvMixColumns; first/last pass raw.
  assign apply_imc = rd_dec && (rd_addr != 4'd0) && (rd_addr < nr_reg);
  assign rd_data   = !rd_ok     ? 128'd0 :
                     apply_imc  ? {inv_mix_col(raw_key[127:96]), inv_mix_col(raw_key[95:64]),
                                   inv_mix_col(raw_key[63:32]),  inv_mix_col(raw_key[31:0])} :
                                  raw_key;
`else
  assign rd_data = rd_ok ? raw_key : 128'd0;
`endif

  assign busy      = (state_reg == LOAD) || (state_reg == EXPAND);
  assign done      = (state_reg == FIN);
  assign key_valid = key_valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
`timescale 1ns/1ps
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rd_addr;
  logic         rd_dec;
  logic         busy, done, key_valid, err;
  logic [127:0] rd_data;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .rd_addr(rd_addr), .rd_dec(rd_dec), .busy(busy), .done(done),
    .key_valid(key_valid), .err(err), .rd_data(rd_data)
  );

`ifdef AES_KEY_INV_MIX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------ reference model
  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [7:0]  sbox_tab [256];
  logic [31:0] ref_w [60];
  int          ref_nr = 10;
  bit          ref_valid = 1'b0;

  task automatic init_sbox();
    logic [127:0] row;
    for (int r = 0; r < 16; r++) begin
      row = SBOX_ROWS[r];
      for (int c = 0; c < 16; c++) sbox_tab[16*r + c] = row[127 - 8*c -: 8];
    end
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input int b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < b; k++) r = r ^ a;           // odd/even adds cancel
    return r;
  endfunction

  // Multiplication in GF(2^8) as a sum of shifted copies reduced by 0x11b.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) acc = acc ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (acc[k]) acc = acc ^ (16'h011b << (k - 8));
    return acc[7:0];
  endfunction

  function automatic logic [31:0] ref_imc(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [7:0] m [4][4];
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    for (int j = 0; j < 4; j++) a[j] = col[31 - 8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'h00;
      for (int j = 0; j < 4; j++) b[i] = b[i] ^ ref_mul(a[j], m[i][j]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic model_expand(input logic [1:0] len, input logic [255:0] key);
    int nk;
    logic [31:0] t;
    nk     = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
    ref_nr = nk + 6;
    for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (ref_nr + 1); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0)
        t = ref_sub({t[23:0], t[31:24]}) ^ {RCON_TAB[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = ref_sub(t);
      ref_w[i] = ref_w[i-nk] ^ t;
    end
    ref_valid = 1'b1;
  endtask

  function automatic logic [127:0] ref_round(input int a, input bit d);
    int r;
    logic [127:0] k;
    if (!ref_valid || a > ref_nr) return 128'd0;
    r = d ? ref_nr - a : a;
    k = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    if (INV_EN && d && a >= 1 && a <= ref_nr - 1)
      for (int c = 0; c < 4; c++) k[127 - 32*c -: 32] = ref_imc(k[127 - 32*c -: 32]);
    return k;
  endfunction

  // ------------------------------------------------------------ checking
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic read_check(input int a, input bit d, input string tag);
    @(negedge clk);
    rd_addr = 4'(a);
    rd_dec  = d;
    #1;
    check($sformatf("%s rd a=%0d d=%0d", tag, a, d), rd_data, ref_round(a, d));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++)
      for (int d = 0; d < 2; d++) read_check(a, d[0], tag);
  endtask

  // Start an expansion and follow it to done. mid_cyc>0 pulses a second
  // start while busy; fin_start raises start during the FIN cycle.
  task automatic run_expand(input logic [1:0] len, input logic [255:0] key, input int exp_lat,
                            input int mid_cyc, input bit fin_start, input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1; key_len = len; key_in = key; rd_addr = 4'd0; rd_dec = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, " busy@1"}, 128'(busy), 128'd1);
        check({tag, " kv@1"}, 128'(key_valid), 128'd0);
        check({tag, " rd zero while invalid"}, rd_data, 128'd0);
      end
      if (mid_cyc > 0 && cyc == mid_cyc) begin
        start = 1'b1; key_len = 2'd2; key_in = ~key;
      end
      if (mid_cyc > 0 && cyc == mid_cyc + 1) begin
        start = 1'b0; key_in = key;
      end
      if (done) seen = 1'b1;
    end
    model_expand(len, key);
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s done timeout: got none within %0d cycles, required %0d", tag, cyc, exp_lat);
    end else begin
      check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
    end
    if (fin_start) begin
      start = 1'b1; key_len = 2'd0; key_in = ~key;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " done pulse ends"}, 128'(done), 128'd0);
    check({tag, " kv after"}, 128'(key_valid), 128'd1);
    check({tag, " idle after"}, 128'(busy), 128'd0);
  endtask

  // ---------------------------------------------------------- directed set
  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    bit           dec;
    logic [3:0]   addr;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  vec_t vecs [5];

  initial begin
    logic [255:0] rkey;
    logic [1:0]   rlen;
    int           lat;

    init_sbox();
    vecs[0] = '{2'd0, K128, 1'b1, 4'd0,  128'h13111d7fe3944a17f307a78b4d2b30c5, 42};
    vecs[1] = '{2'd0, K128, 1'b1, 4'd10, 128'h000102030405060708090a0b0c0d0e0f, 42};
    vecs[2] = '{2'd1, K192, 1'b0, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, 48};
    vecs[3] = '{2'd2, K256, 1'b1, 4'd15, 128'd0, 54};
    vecs[4] = '{2'd2, K256, 1'b1, 4'd0,  128'h24fc79ccbf0979e9371ac23c6d68de36, 54};

    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rd_addr = 4'd0; rd_dec = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    check("reset err", 128'(err), 128'd0);
    check("reset key_valid", 128'(key_valid), 128'd0);
    check("reset rd_data", rd_data, 128'd0);
    rst = 1'b0;

    // Table-driven FIPS-197 vectors.
    for (int v = 0; v < 5; v++) begin
      run_expand(vecs[v].len, vecs[v].key, vecs[v].lat, 0, 1'b0, $sformatf("vec%0d", v));
      @(negedge clk);
      rd_addr = vecs[v].addr; rd_dec = vecs[v].dec;
      #1;
      check($sformatf("vec%0d known key", v), rd_data, vecs[v].exp);
      read_check(1, 1'b1, $sformatf("vec%0d", v));
      read_check(int'(vecs[v].addr), vecs[v].dec, $sformatf("vec%0d model", v));
    end

    // Reserved key_len: err pulse, nothing else changes (AES-256 still held).
    @(negedge clk);
    start = 1'b1; key_len = 2'b11; key_in = ~K256;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("err pulse", 128'(err), 128'd1);
    check("err busy", 128'(busy), 128'd0);
    @(negedge clk);
    check("err pulse ends", 128'(err), 128'd0);
    check("err keeps valid", 128'(key_valid), 128'd1);
    read_check(0, 1'b1, "after err");
    read_check(7, 1'b0, "after err");

    // Reset 20 cycles into an AES-256 run: abort with no done.
    @(negedge clk);
    start = 1'b1; key_len = 2'd2; key_in = K256;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    ref_valid = 1'b0;
    check("abort busy", 128'(busy), 128'd0);
    check("abort key_valid", 128'(key_valid), 128'd0);
    check("abort rd_data", rd_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      check("abort no done", 128'(saw_done), 128'd0);
    end
    run_expand(2'd0, K128, 42, 0, 1'b0, "post-abort");
    @(negedge clk);
    rd_addr = 4'd0; rd_dec = 1'b1;
    #1;
    check("post-abort known key", rd_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Start while busy and start during FIN must both be ignored.
    run_expand(2'd1, K192, 48, 10, 1'b1, "ignore-starts");
    read_check(12, 1'b0, "ignore-starts");

    // Randomized keys and lengths against the model, full read sweep.
    for (int n = 0; n < 6; n++) begin
      rlen = 2'($urandom_range(0, 2));
      for (int j = 0; j < 8; j++) rkey[255 - 32*j -: 32] = $urandom;
      lat = (rlen == 2'd0) ? 42 : (rlen == 2'd1) ? 48 : 54;
      run_expand(rlen, rkey, lat, (n % 2 == 1) ? 5 + n : 0, n[0], $sformatf("rand%0d", n));
      sweep($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-005 key_len  input  2  key length: 00=128, 01=192, 10=256, 11=reserved.
REQ-006 key_in  input  256  cipher key, big-endian; key byte 0 is key_in[255:248]; shorter keys are left-aligned.
REQ-007 rd_addr  input  4  round-key index, 0..Nr.
REQ-008 rd_dec  input  1  read order: 0 selects encryption order (round rd_addr); 1 selects decryption order (round Nr-rd_addr).
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  single-cycle pulse when expansion completes.
REQ-011 key_valid  output  1  high while the store holds a complete schedule.
REQ-012 err  output  1  single-cycle pulse on a reserved key_len at start.
REQ-013 rd_data  output  128  combinational read of the selected round key.
REQ-014 Parameter MAX_KEY_BITS, default 256, maximum supported key length (128, 192 or 256); the word store is sized to 4*(Nr_max+1) x 32.

Function
REQ-015 Nk/Nr SHALL be 4/10, 6/12 and 8/14 for 128/192/256.
REQ-016 FSM states SHALL be IDLE, LOAD, EXPAND and FIN.
REQ-017 IDLE with start=1 and a legal key_len (<= MAX_KEY_BITS) SHALL go to LOAD, latch Nk and Nr, and clear key_valid.
REQ-018 IDLE with start=1 and an illegal or reserved key_len SHALL pulse err the next cycle, remain in IDLE, and leave the store and key_valid unchanged.
REQ-019 LOAD SHALL write w[0..Nk-1] from key_in in a single cycle.
REQ-020 EXPAND SHALL produce one word per cycle, w[i] for i = Nk..4*Nr+3, per FIPS-197.
- i mod Nk == 0: w[i] = w[i-Nk] xor SubWord(RotWord(w[i-1])) xor Rcon.
- Nk==8 and i mod 8 == 4: w[i] = w[i-8] xor SubWord(w[i-1]).
- Otherwise: w[i] = w[i-Nk] xor w[i-1].
REQ-021 i mod Nk SHALL be tracked with a wrap counter (no divider).
REQ-022 Rcon SHALL start at 0x01 and advance by GF(2^8) xtime after each use.
REQ-023 After the last word is written, the FSM SHALL enter FIN for one cycle: done=1, key_valid=1, then return to IDLE.
REQ-024 Latency from the start-accept edge to the done pulse SHALL be 1+4*(Nr+1)-Nk+1 cycles: 42 (128), 48 (192) and 54 (256).
REQ-025 start while busy SHALL be ignored.
REQ-026 start in the FIN cycle SHALL be ignored.
REQ-027 rd_data SHALL be w[4r..4r+3] concatenated, w[4r] in the MSBs, where r = rd_addr (rd_dec=0) or Nr-rd_addr (rd_dec=1).
REQ-028 rd_data SHALL be all-zero when key_valid=0.
REQ-029 rd_data SHALL be all-zero when rd_addr > Nr.

Reset
REQ-030 rst SHALL force IDLE, busy=0, done=0, err=0, key_valid=0, Rcon=0x01 and the counters to 0; rd_data SHALL read zero.
REQ-031 Asserting rst mid-EXPAND SHALL abort the expansion with no done pulse; store contents are don't-care because key_valid=0.

Configuration
REQ-032 With macro AES_KEY_INV_MIX_EN defined, rd_data for rd_dec=1 and 1 <= rd_addr <= Nr-1 SHALL have InvMixColumns applied per column, giving equivalent-inverse-cipher round keys; rounds 0 and Nr SHALL pass unmodified.
REQ-033 Without AES_KEY_INV_MIX_EN, the InvMixColumns logic SHALL be absent and rd_data SHALL be the raw schedule in all cases.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- AES-128: key 000102..0f, start. Expect done at cycle 42; rd_dec=1, rd_addr=0 -> 13111d7fe3944a17f307a78b4d2b30c5.
- AES-192: key 000102..17. Expect done at cycle 48; rd_dec=0, rd_addr=12 -> a4970a331a78dc09c418c271e3a41d5d.
- AES-256: key 000102..1f. Expect done at cycle 54; rd_dec=1, rd_addr=0 -> 24fc79ccbf0979e9371ac23c6d68de36; rd_addr=15 -> zero.
- key_len=11 with start -> err pulse, busy stays 0; a prior schedule stays readable with key_valid=1.
- rst asserted at cycle 20 of an AES-256 run -> no done, key_valid=0; a fresh AES-128 start then matches scenario 1.
- With AES_KEY_INV_MIX_EN, AES-128, rd_dec=1, rd_addr=1 -> InvMixColumns(round-9 key), checked against a reference model; rd_addr=10 -> raw round-0 key 000102..0f.
